// File: rtl/skid_crd_tx_if.sv
// Handshake/credit bundle between an upstream source, the credit transmitter
// and the downstream credit-counted skid buffer.
interface skid_crd_tx_if #(
    parameter int NB = 40,
    parameter int CW = 3
);
    logic [NB-1:0] in_tdata;
    logic          in_tvalid;
    logic          in_tready;
    logic [NB-1:0] out_tdata;
    logic          out_tvalid;
    logic          crd_ret;
    logic [CW-1:0] crd_cnt;
    logic [1:0]    link_state;
    logic          crd_err;

    modport master (
        input  in_tdata, in_tvalid, crd_ret,
        output in_tready, out_tdata, out_tvalid, crd_cnt, link_state, crd_err
    );

    modport slave (
        output in_tdata, in_tvalid, crd_ret,
        input  in_tready, out_tdata, out_tvalid, crd_cnt, link_state, crd_err
    );
endinterface

// File: rtl/skid_crd_tx.sv
// Credit-based transmitter: one credit per forwarded beat, one back per crd_ret.
// Optional sticky overflow detection is built when SKID_CRD_TX_CHECK_EN is defined.
module skid_crd_tx #(
    parameter int n       = 5,
    parameter int nb      = n * 8,
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input logic              aclk,
    input logic              aresetn,
    skid_crd_tx_if.master    bus
);
    localparam logic [1:0]    ST_IDLE   = 2'b10;
    localparam logic [1:0]    ST_ACTIVE = 2'b11;
    localparam logic [1:0]    ST_STALL  = 2'b01;
    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE  = CW'(1);
    localparam logic [CW-1:0] CRED_ZERO = CW'(0);

    logic [CW-1:0] crd_cnt_q,    crd_cnt_d;
    logic [1:0]    link_state_q, link_state_d;
    logic [nb-1:0] out_tdata_q,  out_tdata_d;
    logic          out_tvalid_q, out_tvalid_d;
    logic          in_tready_s;
    logic          is_send_s;

    // Ready looks only at the registered count, so a returning credit is usable one cycle later.
    assign in_tready_s = (crd_cnt_q != CRED_ZERO);
    assign is_send_s   = bus.in_tvalid & in_tready_s;

    // Next credit count; a return while full saturates instead of wrapping.
    always_comb begin
        crd_cnt_d = crd_cnt_q;
        case ({is_send_s, bus.crd_ret})
            2'b10: crd_cnt_d = crd_cnt_q - CRED_ONE;
            2'b01: begin
                if (crd_cnt_q == CRED_MAX) begin
                    crd_cnt_d = crd_cnt_q;
                end else begin
                    crd_cnt_d = crd_cnt_q + CRED_ONE;
                end
            end
            default: crd_cnt_d = crd_cnt_q;
        endcase
    end

    // Link status decoded from the count about to be registered.
    always_comb begin
        link_state_d = ST_ACTIVE;
        if (crd_cnt_d == CRED_MAX) begin
            link_state_d = ST_IDLE;
        end else if (crd_cnt_d == CRED_ZERO) begin
            link_state_d = ST_STALL;
        end else begin
            link_state_d = ST_ACTIVE;
        end
    end

    // Output beat: pulse on send, payload held between sends.
    always_comb begin
        out_tvalid_d = is_send_s;
        if (is_send_s) begin
            out_tdata_d = bus.in_tdata;
        end else begin
            out_tdata_d = out_tdata_q;
        end
    end

    // State and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            crd_cnt_q    <= CRED_MAX;
            link_state_q <= ST_IDLE;
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= {nb{1'b0}};
        end else begin
            crd_cnt_q    <= crd_cnt_d;
            link_state_q <= link_state_d;
            out_tvalid_q <= out_tvalid_d;
            out_tdata_q  <= out_tdata_d;
        end
    end

`ifdef SKID_CRD_TX_CHECK_EN
    logic overflow_s;
    logic crd_err_q;

    assign overflow_s = bus.crd_ret & ~is_send_s & (crd_cnt_q == CRED_MAX);

    // Sticky overflow flag; only a reset clears it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            crd_err_q <= 1'b0;
        end else begin
            if (overflow_s) begin
                crd_err_q <= 1'b1;
                $error("skid_crd_tx: credit returned while all %0d credits held", CREDITS);
            end else begin
                crd_err_q <= crd_err_q;
            end
        end
    end

    assign bus.crd_err = crd_err_q;
`else
    assign bus.crd_err = 1'b0;
`endif

    assign bus.in_tready  = in_tready_s;
    assign bus.out_tvalid = out_tvalid_q;
    assign bus.out_tdata  = out_tdata_q;
    assign bus.crd_cnt    = crd_cnt_q;
    assign bus.link_state = link_state_q;
endmodule

// File: tb/tb_skid_crd_tx.sv
// Directed vector table plus reset and random-traffic sequences for skid_crd_tx.
module tb_skid_crd_tx;
    localparam int NB = 40;
    localparam int CW = 3;
    localparam logic [1:0] IDLE   = 2'b10;
    localparam logic [1:0] ACTIVE = 2'b11;
    localparam logic [1:0] STALL  = 2'b01;
`ifdef SKID_CRD_TX_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    typedef struct {
        logic          vld;
        logic [NB-1:0] data;
        logic          ret;
        logic          e_ov;
        logic [NB-1:0] e_od;
        logic [CW-1:0] e_cnt;
        logic [1:0]    e_ls;
        logic          e_rdy;
        logic          e_err;
    } vec_t;

    logic aclk;
    logic aresetn;
    int   n_chk;
    int   n_pass;
    vec_t vecs[$];
    logic [NB-1:0] sb[$];

    skid_crd_tx_if #(.NB(NB), .CW(CW)) bus ();

    skid_crd_tx #(.n(5), .CREDITS(4)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.master)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic vld, input logic [NB-1:0] data, input logic ret,
                       input logic e_ov, input logic [NB-1:0] e_od, input logic [CW-1:0] e_cnt,
                       input logic [1:0] e_ls, input logic e_rdy, input logic e_err);
        vec_t v;
        v.vld = vld; v.data = data; v.ret = ret;
        v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        v.e_ls = e_ls; v.e_rdy = e_rdy; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic chk_state(input string tag, input logic ov, input logic [NB-1:0] od,
                             input logic [CW-1:0] cnt, input logic [1:0] ls,
                             input logic rdy, input logic err);
        chk({tag, ".out_tvalid"}, 64'(bus.out_tvalid), 64'(ov));
        chk({tag, ".out_tdata"},  64'(bus.out_tdata),  64'(od));
        chk({tag, ".crd_cnt"},    64'(bus.crd_cnt),    64'(cnt));
        chk({tag, ".link_state"}, 64'(bus.link_state), 64'(ls));
        chk({tag, ".in_tready"},  64'(bus.in_tready),  64'(rdy));
        chk({tag, ".crd_err"},    64'(bus.crd_err),    64'(err));
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        bus.in_tvalid = 1'b0;
        bus.in_tdata  = '0;
        bus.crd_ret   = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        logic [NB-1:0] d0;
        logic [2:0]    dly;
        logic          last_acc;
        logic          last_ret;
        int            inflight;
        int            sent;
        int            recv;
        int            cyc;

        n_chk = 0;
        n_pass = 0;
        d0 = 40'h01_0203_0405;

        // Burst to exhaustion, then a single returned credit reused.
        for (int i = 0; i < 4; i++)
            add(1'b1, d0 + NB'(i), 1'b0, 1'b1, d0 + NB'(i), CW'(3 - i),
                (i == 3) ? STALL : ACTIVE, (i != 3), 1'b0);
        add(1'b1, d0 + NB'(4), 1'b0, 1'b0, d0 + NB'(3), 3'd0, STALL,  1'b0, 1'b0);
        add(1'b1, d0 + NB'(4), 1'b1, 1'b0, d0 + NB'(3), 3'd1, ACTIVE, 1'b1, 1'b0);
        add(1'b1, d0 + NB'(4), 1'b0, 1'b1, d0 + NB'(4), 3'd0, STALL,  1'b0, 1'b0);
        add(1'b0, d0 + NB'(4), 1'b1, 1'b0, d0 + NB'(4), 3'd1, ACTIVE, 1'b1, 1'b0);
        add(1'b0, d0 + NB'(4), 1'b1, 1'b0, d0 + NB'(4), 3'd2, ACTIVE, 1'b1, 1'b0);
        // Send and return together hold the count at 2.
        for (int i = 0; i < 10; i++)
            add(1'b1, 40'hAB_0000_0010 + NB'(i), 1'b1, 1'b1, 40'hAB_0000_0010 + NB'(i),
                3'd2, ACTIVE, 1'b1, 1'b0);
        add(1'b0, 40'h0, 1'b1, 1'b0, 40'hAB_0000_0019, 3'd3, ACTIVE, 1'b1, 1'b0);
        add(1'b0, 40'h0, 1'b1, 1'b0, 40'hAB_0000_0019, 3'd4, IDLE,   1'b1, 1'b0);
        // Full: send+return is legal, a bare return is an overflow that saturates.
        add(1'b1, 40'hCD_0000_0020, 1'b1, 1'b1, 40'hCD_0000_0020, 3'd4, IDLE, 1'b1, 1'b0);
        add(1'b0, 40'h0, 1'b1, 1'b0, 40'hCD_0000_0020, 3'd4, IDLE, 1'b1, ERR_ON);
        add(1'b0, 40'h0, 1'b0, 1'b0, 40'hCD_0000_0020, 3'd4, IDLE, 1'b1, ERR_ON);
        add(1'b0, 40'h0, 1'b0, 1'b0, 40'hCD_0000_0020, 3'd4, IDLE, 1'b1, ERR_ON);

        do_reset();
        chk_state("reset", 1'b0, '0, 3'd4, IDLE, 1'b1, 1'b0);

        foreach (vecs[k]) begin
            bus.in_tvalid = vecs[k].vld;
            bus.in_tdata  = vecs[k].data;
            bus.crd_ret   = vecs[k].ret;
            @(posedge aclk);
            @(negedge aclk);
            chk_state($sformatf("vec%0d", k), vecs[k].e_ov, vecs[k].e_od, vecs[k].e_cnt,
                      vecs[k].e_ls, vecs[k].e_rdy, vecs[k].e_err);
        end

        // Asynchronous reset mid-burst.
        do_reset();
        bus.in_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_tdata = 40'h55_0000_0000 + NB'(i);
            @(posedge aclk);
        end
        #2;
        chk("pre_rst.out_tvalid", 64'(bus.out_tvalid), 64'd1);
        chk("pre_rst.crd_cnt",    64'(bus.crd_cnt),    64'd1);
        aresetn = 1'b0;
        #1;
        chk_state("mid_rst", 1'b0, '0, 3'd4, IDLE, 1'b1, 1'b0);
        @(negedge aclk);
        bus.in_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;

        // Random traffic against a receiver returning each credit a few cycles later.
        dly = 3'b000; last_acc = 1'b0; last_ret = 1'b0;
        inflight = 0; sent = 0; recv = 0; cyc = 0;
        while (recv < 1000 && cyc < 20000) begin
            @(negedge aclk);
            cyc++;
            chk("rnd.out_tvalid", 64'(bus.out_tvalid), 64'(last_acc));
            if (bus.out_tvalid) begin
                if (sb.size() == 0) begin
                    chk("rnd.unexpected_beat", 64'd1, 64'd0);
                end else begin
                    chk("rnd.out_tdata", 64'(bus.out_tdata), 64'(sb.pop_front()));
                end
                recv++;
            end
            inflight = inflight + int'(last_acc) - int'(last_ret);
            chk("rnd.crd_cnt", 64'(bus.crd_cnt), 64'(4 - inflight));
            chk("rnd.inflight_le4", 64'(inflight <= 4), 64'd1);
            dly = {dly[1:0], bus.out_tvalid};
            bus.crd_ret = dly[2];
            last_ret = dly[2];
            if (!(bus.in_tvalid && !last_acc)) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    bus.in_tvalid = 1'b1;
                    bus.in_tdata  = 40'h0A_0000_0000 + NB'(sent);
                end else begin
                    bus.in_tvalid = 1'b0;
                end
            end
            last_acc = bus.in_tvalid & bus.in_tready;
            if (last_acc) begin
                sb.push_back(bus.in_tdata);
                sent++;
            end
        end
        chk("rnd.beats_received", 64'(recv), 64'd1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/skid_crd_tx.md
Name: skid_crd_tx

Overview:
- Credit-based transmitter. It is the upstream end of the credit-flow link whose receiver is a credit-counted skid buffer.
- Accepts AXI-stream-style valid/ready beats on its input side. Forwards each beat as a registered, ready-less valid pulse.
- Spends one credit per beat and regains one credit per crd_ret pulse from the receiver. It therefore never sends more beats than the receiver has buffer slots.

Parameters:
- n, 5: payload width in bytes.
- nb, n*8: payload width in bits.
- CREDITS, 4: initial credit count, equal to the receiver's buffer depth. Legal range 1..15.
- CW, $clog2(CREDITS+1): width of the credit counter.

Ports:
- aclk  input  1  clock; all logic on the rising edge.
- aresetn  input  1  asynchronous active-low reset.
- in_tdata  input  nb  upstream payload.
- in_tvalid  input  1  upstream beat valid.
- in_tready  output  1  upstream ready; high when at least one credit is held.
- out_tdata  output  nb  payload sent to the receiver (registered).
- out_tvalid  output  1  one-cycle pulse per beat sent (registered); has no back-pressure.
- crd_ret  input  1  credit return from the receiver; each high cycle returns exactly one credit.
- crd_cnt  output  CW  credits currently held (registered).
- link_state  output  2  status: 2'b10 IDLE, 2'b11 ACTIVE, 2'b01 STALL.
- crd_err  output  1  sticky credit-overflow flag (see Optional Feature).

Behaviour:
- Reset (aresetn low, asynchronous, takes effect immediately, including mid-transfer):
  - crd_cnt = CREDITS, out_tvalid = 0, out_tdata = 0, crd_err = 0, link_state = IDLE.
  - Any beat in flight is dropped, with no partial output.
- in_tready = (crd_cnt != 0). It is a combinational decode of the registered counter only, never of crd_ret.
- Send: is_send = in_tvalid & in_tready.
  - Next cycle: out_tvalid = is_send. On is_send, out_tdata <= in_tdata; otherwise out_tdata holds its value.
  - Latency from input beat to output pulse is 1 cycle. Back-to-back beats produce back-to-back pulses.
- Credit counter update, keyed on {is_send, crd_ret}:
  - 10: crd_cnt - 1.
  - 01: crd_cnt + 1.
  - 11: unchanged.
  - 00: unchanged.
- Boundary, crd_cnt == 0 with crd_ret high: in_tready stays 0 in that cycle. The credit becomes usable the next cycle (crd_cnt = 1).
- Boundary, crd_cnt == 0: no underflow is possible, because is_send is 0.
- Boundary, crd_cnt == CREDITS with crd_ret high and no send: this is an overflow (protocol violation). The counter saturates at CREDITS; it never wraps.
- Boundary, crd_cnt == CREDITS with send and crd_ret in the same cycle: the counter stays at CREDITS. This is legal.
- link_state is registered and derived from the next counter value:
  - IDLE when next crd_cnt == CREDITS.
  - STALL when next crd_cnt == 0.
  - ACTIVE otherwise.
- Transitions follow the counter:
  - IDLE -> ACTIVE on a send.
  - ACTIVE -> STALL on the last credit spent.
  - STALL -> ACTIVE on a credit returned.
  - ACTIVE -> IDLE on the last credit returned.
  - With CREDITS == 1, IDLE <-> STALL directly.
- Holding in_tvalid high while in_tready is low is legal; in_tdata must remain stable (AXI rule).

Optional Feature:
- Macro: SKID_CRD_TX_CHECK_EN.
- Defined:
  - crd_err sets on the cycle after a crd_ret arrives with crd_cnt == CREDITS and no send in that cycle.
  - crd_err is sticky until reset.
  - A simulation-only $error is also issued.
- Undefined:
  - crd_err is tied to 0 and no check logic is built.
  - Saturation behaviour is unchanged.

Test Plan:
1. Reset, then hold in_tvalid=1 with data 0x0102030405 onward (incrementing), crd_ret=0 -> exactly 4 out_tvalid pulses carrying 0x0102030405..0x0102030408 on consecutive cycles; crd_cnt 4,3,2,1,0; link_state IDLE->ACTIVE->STALL; in_tready low after the 4th beat.
2. From STALL, pulse crd_ret for 1 cycle -> crd_cnt=1 the next cycle, in_tready=1 that cycle, and exactly one more beat is sent with a 1-cycle output latency.
3. crd_cnt=2, send and crd_ret in the same cycle for 10 cycles -> crd_cnt stays 2; 10 consecutive out_tvalid pulses with matching data.
4. IDLE (crd_cnt=4), crd_ret=1 with no send -> crd_cnt stays 4. With SKID_CRD_TX_CHECK_EN, crd_err=1 the next cycle and it remains 1. Without the macro, crd_err=0.
5. Drop aresetn mid-burst at crd_cnt=1 with out_tvalid=1 -> out_tvalid=0, crd_cnt=4, link_state=IDLE, crd_err=0 immediately, before the next clock edge.
6. Random in_tvalid with a receiver model returning credits after a 3-cycle delay, 1000 beats -> no data loss or reorder; crd_cnt never exceeds 4; beats in flight never exceed 4.
